// File: rtl/multi_bit_sync_filter.sv
// Multi-channel level synchronizer with per-channel glitch filter and
// registered rise/fall edge pulses. Each IN bit passes through a STAGES-deep
// flop chain, then must differ from OUT for FILTER_LEN consecutive cycles
// before OUT follows it.
// Optional build macro SYNC_GRAY_CHECK_EN adds a sticky GRAY_ERR flag that is
// set whenever more than one synchronized bit changes between two cycles.
module multi_bit_sync_filter #(
  parameter int              WIDTH      = 4,
  parameter int              STAGES     = 2,
  parameter int              FILTER_LEN = 3,
  parameter logic [WIDTH-1:0] RST_VAL   = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] IN,
  output logic [WIDTH-1:0] OUT,
  output logic [WIDTH-1:0] RISE_PULSE,
`ifdef SYNC_GRAY_CHECK_EN
  output logic [WIDTH-1:0] FALL_PULSE,
  output logic             GRAY_ERR
`else
  output logic [WIDTH-1:0] FALL_PULSE
`endif
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]             raw;
  logic [CW-1:0]                cnt [WIDTH];

  assign raw = sync_q[STAGES-1];

  // Plain flop chain per bit; nothing may sit between the stages.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q[0] <= IN;
      for (int k = 1; k < STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  // Stability counters, filtered output and edge pulses, one channel per bit.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      OUT        <= RST_VAL;
      RISE_PULSE <= '0;
      FALL_PULSE <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      RISE_PULSE <= '0;
      FALL_PULSE <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (raw[i] == OUT[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          // Qualified change: update the level and flag its direction.
          OUT[i]        <= raw[i];
          RISE_PULSE[i] <= raw[i];
          FALL_PULSE[i] <= ~raw[i];
          cnt[i]        <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

`ifdef SYNC_GRAY_CHECK_EN
  logic [WIDTH-1:0] prev_raw;
  logic [WIDTH-1:0] raw_diff;

  assign raw_diff = raw ^ prev_raw;

  // Sticky flag: a nonzero value with more than one bit set survives x&(x-1).
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      prev_raw <= RST_VAL;
      GRAY_ERR <= 1'b0;
    end else begin
      prev_raw <= raw;
      if ((raw_diff & (raw_diff - WIDTH'(1))) != '0) begin
        GRAY_ERR <= 1'b1;
      end
    end
  end
`endif

endmodule
